// File: rtl/xillybus_tx_sched.sv
// Round-robin scheduler sharing one PCIe TX packet engine among NCH stream channels.
// Issues one bounded-length command, holds the grant until done or watchdog abort, then idles GAP cycles.
module xillybus_tx_sched #(
  parameter int unsigned NCH       = 3,
  parameter int unsigned LENW      = 10,
  parameter int unsigned MAX_BURST = 128,
  parameter int unsigned GAP       = 2,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic                   bus_clk,
  input  logic                   trn_reset_n,
  input  logic                   trn_lnk_up_n,
  input  logic                   quiesce,
  input  logic [NCH-1:0]         ch_req,
  input  logic [NCH*LENW-1:0]    ch_len,
  input  logic                   tx_ready,
  input  logic                   tx_done,
  output logic                   cmd_valid,
  output logic [2:0]             cmd_chan,
  output logic [LENW-1:0]        cmd_len,
  output logic [NCH-1:0]         grant,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int unsigned     PW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [LENW-1:0] MaxLen   = LENW'(MAX_BURST);
  localparam logic [15:0]     WdogLast = 16'(TIMEOUT - 1);
  localparam logic [3:0]      GapLast  = 4'(GAP - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHoldoff} state_e;

  state_e            state_q, state_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [2:0]        cmd_chan_q, cmd_chan_d;
  logic [LENW-1:0]   cmd_len_q, cmd_len_d;
  logic [NCH-1:0]    grant_q, grant_d;
  logic              timeout_err_q, timeout_err_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [15:0]       wdog_q, wdog_d;
  logic [3:0]        gap_q, gap_d;

  logic [NCH-1:0]    elig;
  logic              found;
  logic [PW-1:0]     sel;
  logic [LENW-1:0]   sel_len, issue_len;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      elig[i] = ch_req[i] && (ch_len[i*LENW +: LENW] != '0);
    end
  end

  // First eligible channel at or after the round-robin pointer.
  always_comb begin : p_select
    logic [PW-1:0] idx;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = PW'((32'(ptr_q) + k) % NCH);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    sel_len   = ch_len[32'(sel)*LENW +: LENW];
    issue_len = (sel_len > MaxLen) ? MaxLen : sel_len;
  end

  always_comb begin
    state_d       = state_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_chan_d    = cmd_chan_q;
    cmd_len_d     = cmd_len_q;
    grant_d       = grant_q;
    timeout_err_d = timeout_err_q;
    ptr_d         = ptr_q;
    wdog_d        = wdog_q;
    gap_d         = gap_q;

    if (trn_lnk_up_n) begin
      // Link loss aborts everything but keeps fairness position and the error flag.
      state_d     = StIdle;
      cmd_valid_d = 1'b0;
      grant_d     = '0;
      wdog_d      = '0;
      gap_d       = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!quiesce && found) begin
            state_d     = StIssue;
            cmd_valid_d = 1'b1;
            cmd_chan_d  = 3'(sel);
            cmd_len_d   = issue_len;
            grant_d     = {{(NCH-1){1'b0}}, 1'b1} << sel;
          end
        end
        StIssue: begin
          if (tx_ready) begin
            state_d     = StWait;
            cmd_valid_d = 1'b0;
            wdog_d      = '0;
            ptr_d       = (cmd_chan_q == 3'(NCH - 1)) ? '0 : PW'(cmd_chan_q) + PW'(1);
          end
        end
        StWait: begin
          if (tx_done || wdog_q == WdogLast) begin
            // A done arriving on the last watchdog cycle still counts as success.
            grant_d = '0;
            gap_d   = '0;
            state_d = (GAP == 0) ? StIdle : StHoldoff;
            if (!tx_done) timeout_err_d = 1'b1;
          end else begin
            wdog_d = wdog_q + 16'd1;
          end
        end
        StHoldoff: begin
          if (gap_q == GapLast) begin
            state_d = StIdle;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state_q       <= StIdle;
      cmd_valid_q   <= 1'b0;
      cmd_chan_q    <= '0;
      cmd_len_q     <= '0;
      grant_q       <= '0;
      timeout_err_q <= 1'b0;
      ptr_q         <= '0;
      wdog_q        <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_chan_q    <= cmd_chan_d;
      cmd_len_q     <= cmd_len_d;
      grant_q       <= grant_d;
      timeout_err_q <= timeout_err_d;
      ptr_q         <= ptr_d;
      wdog_q        <= wdog_d;
      gap_q         <= gap_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_chan    = cmd_chan_q;
  assign cmd_len     = cmd_len_q;
  assign grant       = grant_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_xillybus_tx_sched.sv
// Bench for xillybus_tx_sched: vector table, hand-written corner sequences, and a randomized
// run compared each cycle against a packet-level reference model.
module tb_xillybus_tx_sched;

  localparam int NCH  = 3;
  localparam int LENW = 10;
  localparam int MAXB = 128;
  localparam int GAP  = 2;
  localparam int TMO  = 4096;

  logic                bus_clk = 1'b0;
  logic                trn_reset_n, trn_lnk_up_n, quiesce, tx_ready, tx_done;
  logic [NCH-1:0]      ch_req;
  logic [NCH*LENW-1:0] ch_len;
  logic                cmd_valid, busy, timeout_err;
  logic [2:0]          cmd_chan;
  logic [LENW-1:0]     cmd_len;
  logic [NCH-1:0]      grant;

  int lens[NCH];
  int n_pass   = 0;
  int n_checks = 0;

  always #5 bus_clk = ~bus_clk;

  xillybus_tx_sched #(
    .NCH(NCH), .LENW(LENW), .MAX_BURST(MAXB), .GAP(GAP), .TIMEOUT(TMO)
  ) dut (
    .bus_clk(bus_clk), .trn_reset_n(trn_reset_n), .trn_lnk_up_n(trn_lnk_up_n),
    .quiesce(quiesce), .ch_req(ch_req), .ch_len(ch_len), .tx_ready(tx_ready),
    .tx_done(tx_done), .cmd_valid(cmd_valid), .cmd_chan(cmd_chan), .cmd_len(cmd_len),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic cyc();
    @(negedge bus_clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pack_lens();
    for (int i = 0; i < NCH; i++) ch_len[i*LENW +: LENW] = LENW'(lens[i]);
  endtask

  task automatic set_lens(input int a, input int b, input int c);
    lens[0] = a; lens[1] = b; lens[2] = c;
    pack_lens();
  endtask

  task automatic apply_reset();
    trn_reset_n = 1'b0; trn_lnk_up_n = 1'b0; quiesce = 1'b0;
    ch_req = '0; set_lens(0, 0, 0); tx_ready = 1'b0; tx_done = 1'b0;
    cyc(); cyc();
    trn_reset_n = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!cmd_valid && n < 20) begin cyc(); n++; end
    check(name, cmd_valid, 1);
  endtask

  // Accept the offered command, complete it, and confirm the grant is released.
  task automatic do_packet(input int ec, input int el);
    tx_ready = 1'b1;
    wait_valid("pkt_valid");
    check("pkt_chan", cmd_chan, ec);
    check("pkt_len", cmd_len, el);
    check("pkt_grant", grant, 1 << ec);
    cyc();
    check("pkt_inflight_valid", cmd_valid, 0);
    check("pkt_inflight_grant", grant, 1 << ec);
    tx_done = 1'b1; cyc(); tx_done = 1'b0;
    check("pkt_release", grant, 0);
  endtask

  // Reference model: tracks whether a packet is offered, in flight or cooling down.
  int m_phase, m_ptr, m_chan, m_len, m_valid, m_grant, m_terr, m_waited, m_cool;

  task automatic m_reset();
    m_phase = 0; m_ptr = 0; m_chan = 0; m_len = 0; m_valid = 0; m_grant = 0;
    m_terr = 0; m_waited = 0; m_cool = 0;
  endtask

  task automatic m_finish(input bit aborted);
    m_grant = 0;
    if (aborted) m_terr = 1;
    m_cool  = GAP;
    m_phase = (GAP == 0) ? 0 : 3;
  endtask

  task automatic m_step();
    int c;
    if (trn_lnk_up_n) begin
      m_phase = 0; m_valid = 0; m_grant = 0; m_waited = 0; m_cool = 0;
    end else begin
      case (m_phase)
        0: if (!quiesce) begin
          for (int k = 0; k < NCH; k++) begin
            c = (m_ptr + k) % NCH;
            if (m_phase == 0 && ch_req[c] && lens[c] != 0) begin
              m_chan = c; m_len = (lens[c] > MAXB) ? MAXB : lens[c];
              m_valid = 1; m_grant = 1 << c; m_phase = 1;
            end
          end
        end
        1: if (tx_ready) begin
          m_valid = 0; m_ptr = (m_chan + 1) % NCH; m_phase = 2; m_waited = 0;
        end
        2: begin
          if (tx_done) m_finish(1'b0);
          else if (m_waited == TMO - 1) m_finish(1'b1);
          else m_waited++;
        end
        default: begin
          m_cool--;
          if (m_cool == 0) m_phase = 0;
        end
      endcase
    end
  endtask

  function automatic int pick_len();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return int'($urandom_range(1, MAXB));
      2:       return int'($urandom_range(MAXB + 1, 1023));
      default: return int'($urandom_range(1, 8));
    endcase
  endfunction

  typedef struct {
    logic [2:0] req;
    int l0, l1, l2;
    int ec;   // -1: no command expected
    int el;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{3'b010, 0,    5, 0,   1, 5};
    vecs[1] = '{3'b111, 0,    7, 9,   1, 7};
    vecs[2] = '{3'b101, 300,  1, 1,   0, 128};
    vecs[3] = '{3'b100, 0,    0, 128, 2, 128};
    vecs[4] = '{3'b011, 1023, 4, 0,   0, 128};
    vecs[5] = '{3'b001, 127,  0, 0,   0, 127};
    vecs[6] = '{3'b110, 5,    0, 0,  -1, 0};
    vecs[7] = '{3'b100, 0,    0, 129, 2, 128};

    // Reset state while reset is held
    trn_reset_n = 1'b0; trn_lnk_up_n = 1'b0; quiesce = 1'b0;
    ch_req = '0; set_lens(0, 0, 0); tx_ready = 1'b0; tx_done = 1'b0;
    cyc();
    check("rst_valid", cmd_valid, 0);
    check("rst_chan", cmd_chan, 0);
    check("rst_len", cmd_len, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);

    // First decision from reset for each vector
    for (int v = 0; v < 8; v++) begin
      apply_reset();
      ch_req = vecs[v].req;
      set_lens(vecs[v].l0, vecs[v].l1, vecs[v].l2);
      cyc();
      if (vecs[v].ec < 0) begin
        check("vec_none_valid", cmd_valid, 0);
        check("vec_none_busy", busy, 0);
      end else begin
        check("vec_valid", cmd_valid, 1);
        check("vec_chan", cmd_chan, vecs[v].ec);
        check("vec_len", cmd_len, vecs[v].el);
        check("vec_grant", grant, 1 << vecs[v].ec);
        check("vec_busy", busy, 1);
      end
    end

    // Single channel: one-cycle latency, done, two holdoff cycles, reissue
    apply_reset();
    ch_req = 3'b010; set_lens(0, 5, 0); tx_ready = 1'b1;
    cyc();
    check("s1_valid", cmd_valid, 1);
    check("s1_chan", cmd_chan, 1);
    check("s1_len", cmd_len, 5);
    check("s1_grant", grant, 3'b010);
    cyc();
    check("s1_wait_valid", cmd_valid, 0);
    check("s1_wait_grant", grant, 3'b010);
    repeat (9) cyc();
    tx_done = 1'b1; cyc(); tx_done = 1'b0;
    check("s1_rel_grant", grant, 0);
    check("s1_hold1_busy", busy, 1);
    cyc();
    check("s1_hold2_busy", busy, 1);
    check("s1_hold2_valid", cmd_valid, 0);
    cyc();
    check("s1_idle_busy", busy, 0);
    check("s1_idle_valid", cmd_valid, 0);
    cyc();
    check("s1_reissue", cmd_valid, 1);
    check("s1_reissue_chan", cmd_chan, 1);

    // Round robin with clamped length and a stalled engine
    apply_reset();
    ch_req = 3'b111; set_lens(300, 300, 300);
    cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("rr_stall_valid", cmd_valid, 1);
      check("rr_stall_chan", cmd_chan, 0);
      check("rr_stall_len", cmd_len, 128);
    end
    do_packet(0, 128);
    do_packet(1, 128);
    do_packet(2, 128);
    do_packet(0, 128);
    do_packet(1, 128);

    // Zero-length channel skipped; quiesce holds off new issue only
    apply_reset();
    ch_req = 3'b111; set_lens(0, 4, 4); tx_ready = 1'b1;
    cyc();
    check("q_chan", cmd_chan, 1);
    cyc();
    quiesce = 1'b1;
    repeat (3) cyc();
    check("q_inflight_grant", grant, 3'b010);
    tx_done = 1'b1; cyc(); tx_done = 1'b0;
    check("q_release", grant, 0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("q_hold", cmd_valid, 0);
    end
    quiesce = 1'b0;
    cyc();
    check("q_resume_valid", cmd_valid, 1);
    check("q_resume_chan", cmd_chan, 2);
    do_packet(2, 4);
    do_packet(1, 4);
    do_packet(2, 4);

    // Watchdog abort, sticky error, and recovery
    apply_reset();
    ch_req = 3'b001; set_lens(5, 0, 0); tx_ready = 1'b1;
    cyc();
    check("wd_valid", cmd_valid, 1);
    repeat (4096) cyc();
    check("wd_pre_grant", grant, 3'b001);
    check("wd_pre_terr", timeout_err, 0);
    cyc();
    check("wd_abort_grant", grant, 0);
    check("wd_abort_terr", timeout_err, 1);
    do_packet(0, 5);
    check("wd_sticky", timeout_err, 1);

    // Link drop during ISSUE keeps the pointer
    apply_reset();
    ch_req = 3'b111; set_lens(3, 3, 3);
    do_packet(0, 3);
    tx_ready = 1'b0;
    wait_valid("ld_valid");
    check("ld_chan", cmd_chan, 1);
    trn_lnk_up_n = 1'b1;
    cyc();
    check("ld_valid_drop", cmd_valid, 0);
    check("ld_grant_drop", grant, 0);
    check("ld_busy_drop", busy, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("ld_no_issue", cmd_valid, 0);
    end
    trn_lnk_up_n = 1'b0;
    do_packet(1, 3);

    // Asynchronous reset while a packet is in flight
    apply_reset();
    ch_req = 3'b111; set_lens(3, 3, 3);
    do_packet(0, 3);
    wait_valid("ar_valid");
    check("ar_chan", cmd_chan, 1);
    cyc();
    check("ar_inflight", grant, 3'b010);
    #2 trn_reset_n = 1'b0;
    #1;
    check("ar_grant", grant, 0);
    check("ar_busy", busy, 0);
    check("ar_chan_clr", cmd_chan, 0);
    check("ar_len_clr", cmd_len, 0);
    cyc();
    trn_reset_n = 1'b1;
    do_packet(0, 3);

    // Randomized run against the reference model
    apply_reset();
    m_reset();
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        ch_req = NCH'($urandom);
        for (int i = 0; i < NCH; i++) lens[i] = pick_len();
        pack_lens();
      end
      tx_ready = ($urandom_range(0, 2) != 0);
      tx_done  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) quiesce = ~quiesce;
      trn_lnk_up_n = ($urandom_range(0, 39) == 0);
      m_step();
      cyc();
      check("rnd_valid", cmd_valid, m_valid);
      check("rnd_chan", cmd_chan, m_chan);
      check("rnd_len", cmd_len, m_len);
      check("rnd_grant", grant, m_grant);
      check("rnd_busy", busy, (m_phase != 0) ? 1 : 0);
      check("rnd_terr", timeout_err, m_terr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xillybus_tx_sched.md
Name: xillybus_tx_sched

Overview:
Round-robin scheduler that shares the single PCIe TX packet engine (64-bit s_axis_tx path) between NCH FPGA-to-host stream channels (read_8, read_32, mem_8 by default). Each cycle it picks one requesting channel and issues a bounded-length packet command. It holds the grant until the engine reports completion, then inserts a gap. It sits between the per-channel read FIFOs and the TX packet builder inside the core.

Parameters:
NCH, 3, number of requesting channels (2..8)
LENW, 10, width of word-count fields
MAX_BURST, 128, max words per packet command (1..2^LENW-1)
GAP, 2, idle cycles between packet completion and next issue (0..15)
TIMEOUT, 4096, cycles allowed in WAIT_DONE before abort (< 2^16)

Ports:
bus_clk  in  1  clock
trn_reset_n  in  1  asynchronous active-low reset
trn_lnk_up_n  in  1  link down when high
quiesce  in  1  stop issuing new commands
ch_req  in  NCH  per-channel: open and non-empty
ch_len  in  NCH*LENW  per-channel words available; channel i at [i*LENW +: LENW]
tx_ready  in  1  TX engine accepts a command this cycle
tx_done  in  1  single-cycle pulse: granted packet fully sent
cmd_valid  out  1  command offered to TX engine
cmd_chan  out  3  granted channel index
cmd_len  out  LENW  words in the packet
grant  out  NCH  one-hot grant to the channel FIFO read side; 0 when none
busy  out  1  state != IDLE
timeout_err  out  1  sticky; set on watchdog abort

Behaviour:
- Reset (async, trn_reset_n low): state IDLE; cmd_valid=0, cmd_chan=0, cmd_len=0, grant=0, busy=0, timeout_err=0; RR pointer=0, all counters=0. Outputs are registered.
- Eligible(i) = ch_req[i] && ch_len[i] != 0. A channel with req high and len 0 is ignored.
- Issue length = min(ch_len[i], MAX_BURST), computed in LENW bits with no truncation.
- States:
  - IDLE: if !quiesce && !trn_lnk_up_n && any eligible, select the first eligible index at or after ptr, modulo NCH. Next cycle: ISSUE, with cmd_valid=1, cmd_chan, cmd_len and grant latched. Latency from eligible to cmd_valid is 1 cycle.
  - ISSUE: hold cmd_valid, cmd_chan and cmd_len stable until tx_ready. On a cycle with cmd_valid && tx_ready: cmd_valid drops next cycle, ptr = chan+1 (wrap to 0 at NCH), go to WAIT_DONE, watchdog cleared. grant stays asserted.
  - WAIT_DONE: on tx_done, grant=0, go to HOLDOFF (or IDLE if GAP=0). The watchdog counts every cycle. On reaching TIMEOUT-1 without tx_done: grant=0, timeout_err=1, go to HOLDOFF.
  - HOLDOFF: count GAP cycles, then IDLE.
- tx_done outside WAIT_DONE is ignored. tx_done and the timeout in the same cycle count as done; timeout_err is not set.
- quiesce affects only IDLE. A command already in ISSUE or WAIT_DONE completes normally. Deasserting quiesce allows issue in the following cycle.
- trn_lnk_up_n high in any state: next cycle IDLE, cmd_valid=0, grant=0, counters=0. ptr and timeout_err are retained. No issue while the link is down.
- ch_req or ch_len changing after latch does not alter cmd_len or grant.
- Fairness: with all NCH channels continuously eligible, grants rotate 0,1,...,NCH-1,0. No channel waits more than NCH-1 packets.
- busy=1 in ISSUE, WAIT_DONE and HOLDOFF.

Test Plan:
- Single channel: ch_req=3'b010, ch_len[1]=5, tx_ready=1 -> cmd_valid 1 cycle after req with cmd_chan=1, cmd_len=5, grant=3'b010. tx_done 10 cycles later -> grant=0, 2 idle cycles, then the next issue.
- Round-robin: all channels eligible with len 300 -> cmd_len=128 each time, channel order 0,1,2,0,1. tx_ready held low 4 cycles -> cmd_valid and fields stable throughout.
- Zero-length and quiesce: ch_req=3'b111 with ch_len[0]=0 -> channel 0 never granted. quiesce=1 during WAIT_DONE -> the current packet completes and no new cmd_valid appears until quiesce=0.
- Watchdog: no tx_done for 4096 cycles -> grant=0 and timeout_err=1 (sticky until reset). A subsequent packet proceeds normally.
- Link drop: trn_lnk_up_n=1 during ISSUE -> cmd_valid=0 and grant=0 next cycle, no issue while high. On return, ptr continues from its previous value.
- Async reset mid-WAIT_DONE: trn_reset_n low between clock edges -> all outputs 0 immediately, restart from channel 0.
